// File: rtl/fluid_board_soc_nios2_qsys_0_oci_dct_ctrl.sv
// OCI data-trace capture controller: packs trace frames into dct_buffer and writes packed words to trace RAM.
// Optional drop counter enabled by defining FLUID_DCT_DROP_CNT_EN.
module fluid_board_soc_nios2_qsys_0_oci_dct_ctrl #(
  parameter int unsigned SLOT_W = 10,
  parameter int unsigned SLOTS  = 3,
  parameter int unsigned ADDR_W = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     flush,
  input  logic                     wrap_en,
  input  logic                     frame_valid,
  input  logic [SLOT_W-1:0]        frame_data,
  output logic                     frame_ready,
  output logic                     tw_valid,
  input  logic                     tw_ready,
  output logic [ADDR_W-1:0]        tw_addr,
  output logic [SLOT_W*SLOTS-1:0]  tw_data,
  output logic [SLOT_W*SLOTS-1:0]  dct_buffer,
  output logic [3:0]               dct_count,
  output logic                     full,
  output logic                     wrapped,
  output logic                     busy,
  output logic [15:0]              drop_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [SLOT_W*SLOTS-1:0] buf_q, buf_d;
  logic [3:0]              count_q, count_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    full_q, full_d;
  logic                    wrapped_q, wrapped_d;
  logic                    pend_q, pend_d;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    count_d   = count_q;
    addr_d    = addr_q;
    full_d    = full_q;
    wrapped_d = wrapped_q;
    pend_d    = pend_q;
    case (state_q)
      IDLE, STOP: begin
        if (arm) begin
          state_d   = FILL;
          buf_d     = '0;
          count_d   = '0;
          addr_d    = '0;
          full_d    = 1'b0;
          wrapped_d = 1'b0;
          pend_d    = 1'b0;
        end
      end
      FILL: begin
        if (frame_valid) begin
          for (int unsigned k = 0; k < SLOTS; k++) begin
            if (count_q == 4'(k)) buf_d[k*SLOT_W +: SLOT_W] = frame_data;
          end
          count_d = count_q + 4'd1;
        end
        // stop and flush both look at the count after any same-cycle accept
        if (stop) begin
          if (count_d != '0) begin
            state_d = WRITE;
            pend_d  = 1'b1;
          end else begin
            state_d = STOP;
          end
        end else if (count_d == 4'(SLOTS) || (flush && count_d != '0)) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (stop) pend_d = 1'b1;
        if (tw_ready) begin
          buf_d   = '0;
          count_d = '0;
          pend_d  = 1'b0;
          if (addr_q == '1 && !wrap_en) begin
            full_d  = 1'b1;
            state_d = STOP;
          end else begin
            addr_d = addr_q + 1'b1;
            if (addr_q == '1) wrapped_d = 1'b1;
            state_d = (stop || pend_q) ? STOP : FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      full_q    <= 1'b0;
      wrapped_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      full_q    <= full_d;
      wrapped_q <= wrapped_d;
      pend_q    <= pend_d;
    end
  end

  assign frame_ready = (state_q == FILL);
  assign tw_valid    = (state_q == WRITE);
  assign busy        = (state_q == FILL) || (state_q == WRITE);
  assign tw_addr     = addr_q;
  assign tw_data     = buf_q;
  assign dct_buffer  = buf_q;
  assign dct_count   = count_q;
  assign full        = full_q;
  assign wrapped     = wrapped_q;

`ifdef FLUID_DCT_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if ((state_q == IDLE || state_q == STOP) && arm) begin
      drop_q <= '0;
    end else if (frame_valid && !frame_ready && busy && drop_q != '1) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule
